mult_arb: RTL

Shares one fixed-latency pipelined 64-bit multiplier wrapper among up to NREQ requesters in a personality. Each cycle it grants at most one valid request (round-robin by default), registers it into the multiplier, and carries a requester tag through a shift pipeline matched to the multiplier latency. Completed products are steered back to the originating requester. Per-requester outstanding-operation counters enforce a credit limit and report idle.

---
 rtl/mult_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mult_arb.sv
// mult_arb: arbitrates NREQ requesters onto one fixed-latency pipelined multiplier and steers
// results back by tag. Define MULT_ARB_PRIO0_EN to give requester 0 strict priority.
module mult_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LAT     = 18,
  parameter int unsigned MAX_OUT = 16
) (
  input  logic                 ck,
  input  logic                 i_reset,
  input  logic [NREQ-1:0]      i_req_vld,
  input  logic [64*NREQ-1:0]   i_req_a,
  input  logic [64*NREQ-1:0]   i_req_b,
  input  logic [9*NREQ-1:0]    i_req_htId,
  output logic [NREQ-1:0]      o_req_rdy,
  output logic [63:0]          o_mul_a,
  output logic [63:0]          o_mul_b,
  output logic [8:0]           o_mul_htId,
  output logic                 o_mul_vld,
  input  logic [63:0]          i_mul_res,
  input  logic [8:0]           i_mul_htId,
  input  logic                 i_mul_vld,
  output logic [NREQ-1:0]      o_rsp_vld,
  output logic [63:0]          o_rsp_res,
  output logic [8:0]           o_rsp_htId,
  output logic                 o_idle,
  output logic                 o_err
);

  localparam int unsigned IdW  = $clog2(NREQ);
  localparam int unsigned SumW = IdW + 1;
  localparam logic [7:0]      MaxOut     = 8'(MAX_OUT);
  localparam logic [SumW-1:0] NreqW      = SumW'(NREQ);
  localparam logic [IdW-1:0]  LastId     = IdW'(NREQ - 1);
  // All tag stages except the output one; used to see what is still in flight next cycle.
  localparam logic [LAT-1:0]  TagLowMask = {LAT{1'b1}} >> 1;

  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]      cnt_q [NREQ];
  logic [7:0]      cnt_d [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            gnt_vld;
  logic [IdW-1:0]  gnt_id;
  logic [SumW-1:0] scan_idx;
  logic [63:0]     sel_a, sel_b;
  logic [8:0]      sel_ht;
  logic [IdW-1:0]  mul_id_q;
  logic [LAT-1:0]  tag_vld_q;
  logic [IdW-1:0]  tag_id_q [LAT];
  logic            tag_vld;
  logic [IdW-1:0]  tag_id;
  logic            busy;
  logic            idle_q, idle_d;
  logic            err_q;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      eligible[i] = i_req_vld[i] && (cnt_q[i] < MaxOut);
    end
  end

  // Round-robin scan starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SumW'(k);
      if (scan_idx >= NreqW) scan_idx = scan_idx - NreqW;
      if (!gnt_vld && eligible[scan_idx[IdW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = scan_idx[IdW-1:0];
      end
    end
`ifdef MULT_ARB_PRIO0_EN
    if (eligible[0]) begin
      gnt_vld = 1'b1;
      gnt_id  = '0;
    end
`endif
    if (i_reset) begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
    end
  end

  always_comb begin
    grant     = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
    o_req_rdy = grant;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (gnt_id == LastId) ? '0 : gnt_id + 1'b1;
`ifdef MULT_ARB_PRIO0_EN
    if (gnt_vld && (gnt_id == '0)) rr_ptr_d = rr_ptr_q;
`endif
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_ht = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a  = i_req_a[64*i +: 64];
        sel_b  = i_req_b[64*i +: 64];
        sel_ht = i_req_htId[9*i +: 9];
      end
    end
  end

  always_comb begin
    tag_vld    = tag_vld_q[LAT-1];
    tag_id     = tag_id_q[LAT-1];
    o_rsp_vld  = (tag_vld && !i_reset) ? (NREQ'(1) << tag_id) : '0;
    o_rsp_res  = i_mul_res;
    o_rsp_htId = i_mul_htId;
  end

  // A simultaneous grant and response cancel out; the decrement guard keeps the count >= 0.
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && !(o_rsp_vld[i] && (cnt_q[i] != 8'd0))) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else if (!grant[i] && o_rsp_vld[i] && (cnt_q[i] != 8'd0)) begin
        cnt_d[i] = cnt_q[i] - 8'd1;
      end
    end
  end

  always_comb begin
    busy = gnt_vld | o_mul_vld | (|(tag_vld_q & TagLowMask));
    for (int unsigned i = 0; i < NREQ; i++) begin
      busy = busy | (cnt_d[i] != 8'd0);
    end
    idle_d = !busy;
  end

  always_ff @(posedge ck) begin
    if (i_reset) begin
      rr_ptr_q   <= '0;
      o_mul_vld  <= 1'b0;
      o_mul_a    <= '0;
      o_mul_b    <= '0;
      o_mul_htId <= '0;
      mul_id_q   <= '0;
      tag_vld_q  <= '0;
      for (int unsigned s = 0; s < LAT; s++) tag_id_q[s] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      o_mul_vld <= gnt_vld;
      if (gnt_vld) begin
        o_mul_a    <= sel_a;
        o_mul_b    <= sel_b;
        o_mul_htId <= sel_ht;
        mul_id_q   <= gnt_id;
      end
      tag_vld_q <= (tag_vld_q << 1) | LAT'(o_mul_vld);
      for (int unsigned s = 1; s < LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
      tag_id_q[0] <= mul_id_q;
      for (int unsigned i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      idle_q <= idle_d;
      err_q  <= err_q | (i_mul_vld != tag_vld);
    end
  end

  assign o_idle = idle_q;
  assign o_err  = err_q;

endmodule
